ballplayer_img_cmd_ctrl: RTL and testbench

- Image-selection command controller between the 4x4 matrix keyboard scanner and the LCD image display.
- Decodes per-key pulses and held-key levels into image commands: direct select, next/prev, hold-to-repeat and auto-slideshow.
- Issues the resulting image ID to the display over a valid/ready handshake.
- Runs on the 12 MHz system clock, same domain as the keyboard and the display request port.

---
 rtl/ballplayer_img_cmd_ctrl_pkg.sv | 35 +++
 rtl/ballplayer_img_cmd_ctrl_if.sv | 20 ++
 rtl/ballplayer_img_cmd_ctrl_hold_repeat.sv | 59 +++++
 rtl/ballplayer_img_cmd_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ballplayer_img_cmd_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ballplayer_img_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ballplayer_pkg
// Description : Shared constants, FSM state type and image-ID step helpers
//               for the image-selection command controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ballplayer_pkg;

    // Image ID width. It covers up to 8 images.
    localparam int ID_W = 3;

    // Key indices for the non-direct-select keys.
    localparam int KEY_PREV = 8;
    localparam int KEY_NEXT = 9;
    localparam int KEY_AUTO = 10;
    localparam int KEY_HOME = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Next ID, wrapping from n-1 back to 0.
    function automatic logic [ID_W-1:0] id_next(input logic [ID_W-1:0] id, input int n);
        return (int'(id) == n - 1) ? '0 : id + ID_W'(1);
    endfunction

    // Previous ID, wrapping from 0 to n-1.
    function automatic logic [ID_W-1:0] id_prev(input logic [ID_W-1:0] id, input int n);
        return (id == '0) ? ID_W'(n - 1) : id - ID_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ballplayer_img_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ballplayer_img_cmd_ctrl_if
// Description : Image request channel to the LCD display (valid/ready).
//               master: controller side, slave: display side.
//               req_valid / req_id flow master->slave, req_ready back.
// Revision    : 1.0 - initial release
// ============================================================================
interface ballplayer_img_cmd_ctrl_if;
    import ballplayer_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;

    modport master (output req_valid, output req_id, input req_ready);
    modport slave  (input req_valid, input req_id, output req_ready);

endinterface
`default_nettype wire

// File: rtl/ballplayer_img_cmd_ctrl_hold_repeat.sv
`default_nettype none
// ============================================================================
// Module      : ballplayer_hold_repeat
// Description : Hold-to-repeat timer for one key. After a start pulse, while
//               the key stays held, fires tick after REPEAT_DLY cycles and
//               then every REPEAT_PER cycles. Releasing the key disarms it.
// Ports       : clk, rst_n     - clock, async active-low reset
//               held           - debounced key level
//               start          - decoded press of this key
//               tick           - one-cycle repeat request
// Revision    : 1.0 - initial release
// ============================================================================
module ballplayer_hold_repeat #(
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 2400000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic held,
    input  wire logic start,
    output logic      tick
);

    localparam int MAX_CNT = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    logic             armed;
    logic             rep_phase;  // 0: initial delay, 1: periodic repeat
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    assign limit = rep_phase ? CNT_W'(REPEAT_PER - 1) : CNT_W'(REPEAT_DLY - 1);
    assign tick  = armed & held & (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            rep_phase <= 1'b0;
            cnt       <= '0;
        end else if (!held) begin
            armed     <= 1'b0;
            rep_phase <= 1'b0;
            cnt       <= '0;
        end else if (start) begin
            armed     <= 1'b1;
            rep_phase <= 1'b0;
            cnt       <= '0;
        end else if (armed) begin
            if (cnt == limit) begin
                cnt       <= '0;
                rep_phase <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ballplayer_img_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ballplayer_img_cmd_ctrl
// Description : Image-selection command controller. Decodes keyboard pulses,
//               hold-repeat and auto-slideshow ticks into a target image ID
//               and forwards it to the display over a valid/ready channel.
// Ports       : clk, rst_n   - 12 MHz clock, async active-low reset
//               key_pulse    - one-cycle press pulses (16 keys)
//               key_out      - debounced held levels (16 keys)
//               req          - image request channel (master)
//               cur_id       - last ID accepted by the display
//               auto_on      - slideshow mode active
//               cmd_pulse    - one cycle per target update
// Revision    : 1.0 - initial release
// ============================================================================
module ballplayer_img_cmd_ctrl
    import ballplayer_pkg::*;
#(
    parameter int NUM_IMAGES = 8,
    parameter int AUTO_CNT   = 36000000,
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 2400000
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [15:0]          key_pulse,
    input  wire logic [15:0]          key_out,
    ballplayer_img_cmd_ctrl_if.master req,
    output logic [ID_W-1:0]           cur_id,
    output logic                      auto_on,
    output logic                      cmd_pulse
);

    localparam int AUTO_W = (AUTO_CNT > 1) ? $clog2(AUTO_CNT) : 1;

    // Keys that mean something: in-range direct selects plus keys 8..11.
    // Masked keys behave as if never pressed, so they cannot win priority.
    localparam logic [7:0]  SEL_MASK = 8'((1 << NUM_IMAGES) - 1);
    localparam logic [15:0] KEY_MASK = {4'b0000, 4'b1111, SEL_MASK};

    logic [15:0]       keys;
    logic              win_hit;
    logic [3:0]        win_idx;
    logic              cmd_valid;
    logic [ID_W-1:0]   cmd_id;
    logic              kbd_evt;
    logic              auto_toggle;
    logic [1:0]        rep_start;   // [0]: prev key, [1]: next key
    logic [1:0]        rep_tick;
    logic              auto_tick;
    logic [AUTO_W-1:0] auto_cnt;
    logic [ID_W-1:0]   target;
    logic              pending;
    logic              pending_d;
    logic              take;
    state_t            state;
    state_t            state_d;
    logic [ID_W-1:0]   req_id_q;
    logic [ID_W-1:0]   req_id_d;
    logic [ID_W-1:0]   cur_id_d;
    logic              unused_keys;

    assign unused_keys = ^{key_out[15:10], key_out[7:0]};

    // ---------------------------------------------------------------- decode
    assign keys = key_pulse & KEY_MASK;

    // Lowest-index valid key wins.
    always_comb begin
        win_hit = 1'b0;
        win_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) begin
                win_hit = 1'b1;
                win_idx = 4'(i);
            end
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_rep
            ballplayer_hold_repeat #(
                .REPEAT_DLY (REPEAT_DLY),
                .REPEAT_PER (REPEAT_PER)
            ) u_rep (
                .clk   (clk),
                .rst_n (rst_n),
                .held  (key_out[KEY_PREV + g]),
                .start (rep_start[g]),
                .tick  (rep_tick[g])
            );
        end
    endgenerate

    assign auto_tick = auto_on & (auto_cnt == AUTO_W'(AUTO_CNT - 1));

    // Priority: key pulses, then prev repeat, next repeat, then auto tick.
    always_comb begin
        cmd_valid   = 1'b0;
        cmd_id      = target;
        kbd_evt     = 1'b0;
        auto_toggle = 1'b0;
        rep_start   = 2'b00;
        if (win_hit) begin
            kbd_evt = 1'b1;
            if (win_idx < 4'd8) begin
                cmd_valid = 1'b1;
                cmd_id    = win_idx[ID_W-1:0];
            end else if (win_idx == 4'(KEY_PREV)) begin
                cmd_valid    = 1'b1;
                cmd_id       = id_prev(target, NUM_IMAGES);
                rep_start[0] = 1'b1;
            end else if (win_idx == 4'(KEY_NEXT)) begin
                cmd_valid    = 1'b1;
                cmd_id       = id_next(target, NUM_IMAGES);
                rep_start[1] = 1'b1;
            end else if (win_idx == 4'(KEY_AUTO)) begin
                auto_toggle = 1'b1;
            end else begin
                cmd_valid = 1'b1;
                cmd_id    = '0;
            end
        end else if (rep_tick[0]) begin
            kbd_evt   = 1'b1;
            cmd_valid = 1'b1;
            cmd_id    = id_prev(target, NUM_IMAGES);
        end else if (rep_tick[1] && !key_out[KEY_PREV]) begin
            // Holding prev as well suppresses next repeats.
            kbd_evt   = 1'b1;
            cmd_valid = 1'b1;
            cmd_id    = id_next(target, NUM_IMAGES);
        end else if (auto_tick) begin
            cmd_valid = 1'b1;
            cmd_id    = id_next(target, NUM_IMAGES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_on   <= 1'b0;
            auto_cnt  <= '0;
            target    <= '0;
            cmd_pulse <= 1'b0;
        end else begin
            auto_on   <= auto_on ^ auto_toggle;
            cmd_pulse <= cmd_valid;
            if (cmd_valid) begin
                target <= cmd_id;
            end
            if (kbd_evt || !auto_on || auto_tick) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= 1'b0;
            req_id_q <= '0;
            cur_id   <= '0;
        end else begin
            state    <= state_d;
            pending  <= pending_d;
            req_id_q <= req_id_d;
            cur_id   <= cur_id_d;
        end
    end

    always_comb begin
        state_d  = state;
        req_id_d = req_id_q;
        cur_id_d = cur_id;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_d  = REQ;
                    req_id_d = target;
                    take     = 1'b1;
                end
            end
            REQ: begin
                if (req.req_ready) begin
                    cur_id_d = req_id_q;
                    if (pending) begin
                        req_id_d = target;
                        take     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new command in the same cycle re-arms pending (last wins).
        pending_d = cmd_valid | (pending & ~take);
    end

    assign req.req_valid = (state == REQ);
    assign req.req_id    = req_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ballplayer_img_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ballplayer_img_cmd_ctrl
// Description : Self-checking bench. A keyboard-level reference model issues
//               expected image IDs into a scoreboard queue; a monitor pops
//               them on each display handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ballplayer_img_cmd_ctrl;
    import ballplayer_pkg::*;

    localparam int NUM  = 8;
    localparam int AUTO = 50;
    localparam int DLY  = 20;
    localparam int PER  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [15:0]     key_pulse = '0;
    logic [15:0]     key_out = '0;
    logic [ID_W-1:0] cur_id;
    logic            auto_on;
    logic            cmd_pulse;

    // Second instance with 6 images for range checks.
    logic [15:0]     key_pulse6 = '0;
    logic [15:0]     key_out6 = '0;
    logic [ID_W-1:0] cur_id6;
    logic            auto_on6;
    logic            cmd_pulse6;

    always #5 clk = ~clk;

    ballplayer_img_cmd_ctrl_if bus ();
    ballplayer_img_cmd_ctrl_if bus6 ();

    ballplayer_img_cmd_ctrl #(
        .NUM_IMAGES (NUM), .AUTO_CNT (AUTO), .REPEAT_DLY (DLY), .REPEAT_PER (PER)
    ) dut (
        .clk (clk), .rst_n (rst_n), .key_pulse (key_pulse), .key_out (key_out),
        .req (bus), .cur_id (cur_id), .auto_on (auto_on), .cmd_pulse (cmd_pulse)
    );

    ballplayer_img_cmd_ctrl #(
        .NUM_IMAGES (6), .AUTO_CNT (AUTO), .REPEAT_DLY (DLY), .REPEAT_PER (PER)
    ) dut6 (
        .clk (clk), .rst_n (rst_n), .key_pulse (key_pulse6), .key_out (key_out6),
        .req (bus6), .cur_id (cur_id6), .auto_on (auto_on6), .cmd_pulse (cmd_pulse6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------ reference model
    int  cyc = 0;
    int  m_target = 0;
    bit  m_auto = 0;
    int  m_auto_ref = 0;   // cycle of the last auto-timer restart
    bit  m_arm [2];        // [0]: prev key, [1]: next key
    int  m_press [2];      // cycle of the decoded press
    bit  exp_pulse = 0;
    bit  exp_auto = 0;
    bit  sb_push = 1;
    int  exp_q [$];

    function automatic bit key_ok(input int j);
        return (j < NUM) || (j >= 8 && j <= 11);
    endfunction

    function automatic void model_reset();
        m_target = 0; m_auto = 0; m_auto_ref = 0;
        m_arm[0] = 0; m_arm[1] = 0;
        exp_pulse = 0; exp_auto = 0;
    endfunction

    function automatic void model(input logic [15:0] kp, input logic [15:0] ko);
        int win;
        bit cmd;
        int id;
        bit tk [2];
        bit atk;
        int d;
        int nxt;
        int prv;
        win = -1; cmd = 0; id = 0;
        nxt = (m_target + 1) % NUM;
        prv = (m_target + NUM - 1) % NUM;
        // Repeat fires DLY cycles after the press, then every PER, while held.
        for (int i = 0; i < 2; i++) begin
            d = cyc - m_press[i];
            tk[i] = m_arm[i] && ko[8+i] && (d >= DLY) && ((d - DLY) % PER == 0);
        end
        atk = m_auto && (cyc - m_auto_ref > 0) && ((cyc - m_auto_ref) % AUTO == 0);
        for (int j = 15; j >= 0; j--) if (kp[j] && key_ok(j)) win = j;
        if (win >= 0) begin
            m_auto_ref = cyc;
            if (win < 8) begin cmd = 1; id = win; end
            else if (win == 8) begin cmd = 1; id = prv; end
            else if (win == 9) begin cmd = 1; id = nxt; end
            else if (win == 10) m_auto = !m_auto;
            else begin cmd = 1; id = 0; end
        end else if (tk[0]) begin
            cmd = 1; id = prv; m_auto_ref = cyc;
        end else if (tk[1] && !ko[8]) begin
            cmd = 1; id = nxt; m_auto_ref = cyc;
        end else if (atk) begin
            cmd = 1; id = nxt;
        end
        for (int i = 0; i < 2; i++) begin
            if (!ko[8+i]) m_arm[i] = 0;
            else if (win == 8 + i) begin m_arm[i] = 1; m_press[i] = cyc; end
        end
        if (cmd) begin
            m_target = id;
            if (sb_push) exp_q.push_back(id);
        end
        exp_pulse = cmd;
        exp_auto  = m_auto;
        cyc++;
    endfunction

    task automatic step(input logic [15:0] kp, input logic [15:0] ko, input logic rdy);
        @(negedge clk);
        chk("cmd_pulse", int'(cmd_pulse), int'(exp_pulse));
        chk("auto_on", int'(auto_on), int'(exp_auto));
        key_pulse     = kp;
        key_out       = ko;
        bus.req_ready = rdy;
        model(kp, ko);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(16'h0, 16'h0, rdy);
    endtask

    // -------------------------------------------------------------- monitor
    int           exp_cur = 0;
    bit           prev_stall = 0;
    logic [2:0]   prev_id = '0;
    int           mon_e;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            exp_cur    = 0;
            prev_stall = 0;
        end else begin
            chk("cur_id", int'(cur_id), exp_cur);
            if (prev_stall && bus.req_valid)
                chk("req_id_stable", int'(bus.req_id), int'(prev_id));
            if (bus.req_valid && bus.req_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req_id", int'(bus.req_id), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("req_id", int'(bus.req_id), mon_e);
                    exp_cur = mon_e;
                end
            end
            prev_stall = bus.req_valid && !bus.req_ready;
            prev_id    = bus.req_id;
        end
    end

    // ------------------------------------------------------------- stimulus
    logic [15:0] r_kp;
    logic [15:0] r_ko;
    int          r_sel;
    int          hold_left = 0;
    int          hold_key = 9;

    initial begin
        bus.req_ready  = 1'b0;
        bus6.req_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", int'(bus.req_valid), 0);
        chk("rst_cur_id", int'(cur_id), 0);
        chk("rst_auto_on", int'(auto_on), 0);
        chk("rst_cmd_pulse", int'(cmd_pulse), 0);
        repeat (3) @(negedge clk);
        #4 rst_n = 1'b1;
        model_reset();

        // Direct select with two-cycle request latency.
        step(16'h0020, 16'h0, 1'b1);
        step(16'h0, 16'h0, 1'b1);
        chk("lat_edge1_valid", int'(bus.req_valid), 0);
        step(16'h0, 16'h0, 1'b1);
        chk("lat_edge2_valid", int'(bus.req_valid), 1);
        chk("lat_edge2_id", int'(bus.req_id), 5);
        idle(3, 1'b1);
        chk("sel5_cur_id", int'(cur_id), 5);

        // Six-image instance: keys 7 and 6 out of range, 5 valid, next wraps.
        key_pulse6 = 16'h0080;
        step(16'h0, 16'h0, 1'b1); key_pulse6 = 16'h0040;
        chk("n6_key7_pulse", int'(cmd_pulse6), 0);
        step(16'h0, 16'h0, 1'b1); key_pulse6 = 16'h0;
        chk("n6_key6_pulse", int'(cmd_pulse6), 0);
        step(16'h0, 16'h0, 1'b1);
        step(16'h0, 16'h0, 1'b1);
        chk("n6_no_req", int'(bus6.req_valid), 0);
        key_pulse6 = 16'h0020;
        step(16'h0, 16'h0, 1'b1); key_pulse6 = 16'h0;
        chk("n6_key5_pulse", int'(cmd_pulse6), 1);
        idle(4, 1'b1);
        chk("n6_cur5", int'(cur_id6), 5);
        key_pulse6 = 16'h0200;
        step(16'h0, 16'h0, 1'b1); key_pulse6 = 16'h0;
        step(16'h0, 16'h0, 1'b1);
        chk("n6_wrap_valid", int'(bus6.req_valid), 1);
        chk("n6_wrap_id", int'(bus6.req_id), 0);

        // Wrap from 7 and coalescing under backpressure.
        step(16'h0080, 16'h0, 1'b1);
        idle(4, 1'b1);
        chk("sel7_cur_id", int'(cur_id), 7);
        sb_push = 0;
        step(16'h0200, 16'h0, 1'b0);
        idle(3, 1'b0);
        chk("wrap_next_id", int'(bus.req_id), 0);
        step(16'h0100, 16'h0, 1'b0);
        step(16'h0, 16'h0, 1'b0);
        step(16'h0100, 16'h0, 1'b0);
        idle(3, 1'b0);
        chk("stall_valid", int'(bus.req_valid), 1);
        chk("stall_id", int'(bus.req_id), 0);
        exp_q.push_back(0);
        exp_q.push_back(6);
        sb_push = 1;
        idle(6, 1'b1);
        chk("b2b_cur_id", int'(cur_id), 6);

        // Simultaneous pulses: key 4 beats key 9.
        step(16'h0210, 16'h0, 1'b1);
        idle(4, 1'b1);
        chk("simul_cur_id", int'(cur_id), 4);

        // Hold next for 41 cycles starting from ID 0.
        step(16'h0800, 16'h0, 1'b1);
        idle(3, 1'b1);
        step(16'h0200, 16'h0200, 1'b1);
        for (int i = 0; i < 40; i++) step(16'h0, 16'h0200, 1'b1);
        idle(15, 1'b1);
        chk("hold_final_cur", int'(cur_id), 6);

        // Auto slideshow, restarted by a key-3 press.
        step(16'h0400, 16'h0, 1'b1);
        idle(29, 1'b1);
        step(16'h0008, 16'h0, 1'b1);
        idle(49, 1'b1);
        chk("auto_key3_cur", int'(cur_id), 3);
        idle(6, 1'b1);
        chk("auto_tick_cur", int'(cur_id), 4);
        step(16'h0400, 16'h0, 1'b1);

        // Randomized keyboard activity with the display always ready.
        for (int c = 0; c < 1500; c++) begin
            r_kp  = '0;
            r_ko  = '0;
            r_sel = int'($urandom_range(0, 99));
            if (r_sel < 8) begin
                r_kp[$urandom_range(0, 15)] = 1'b1;
            end else if (r_sel < 10) begin
                r_kp[$urandom_range(0, 15)] = 1'b1;
                r_kp[$urandom_range(0, 15)] = 1'b1;
            end else if (r_sel < 13 && hold_left == 0) begin
                hold_key        = 8 + int'($urandom_range(0, 1));
                r_kp[hold_key]  = 1'b1;
                hold_left       = int'($urandom_range(1, 45));
            end
            if (hold_left > 0) begin
                r_ko[hold_key] = 1'b1;
                hold_left--;
            end
            step(r_kp, r_ko, 1'b1);
        end
        if (m_auto) step(16'h0400, 16'h0, 1'b1);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step(16'h0, 16'h0, 1'b1);
        chk("random_drain", exp_q.size(), 0);

        // Reset in the middle of a stalled request.
        step(16'h0040, 16'h0, 1'b1);
        idle(5, 1'b1);
        chk("pre_rst_cur", int'(cur_id), 6);
        step(16'h0400, 16'h0, 1'b1);
        sb_push = 0;
        step(16'h0004, 16'h0, 1'b0);
        idle(3, 1'b0);
        chk("pre_rst_valid", int'(bus.req_valid), 1);
        chk("pre_rst_id", int'(bus.req_id), 2);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.req_valid), 0);
        chk("async_rst_cur", int'(cur_id), 0);
        chk("async_rst_auto", int'(auto_on), 0);
        @(negedge clk);
        #4;
        model_reset();
        sb_push = 1;
        rst_n = 1'b1;
        idle(20, 1'b1);
        chk("post_rst_no_req", int'(bus.req_valid), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
